// File: rtl/adc_capture_pkg.sv
// Shared state encoding, default sizes and frame-length helper for the ADC
// capture sequencer.
package adc_capture_pkg;
    localparam int NCH_DEF = 3;
    localparam int DW_DEF  = 32;
    localparam int AW_DEF  = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_BANK = 2'd2
    } state_t;

    // A programmed length of zero selects a full bank.
    function automatic int eff_len(input int len, input int aw);
        return (len == 0) ? (1 << aw) : len;
    endfunction
endpackage

// File: rtl/adc_capture_sequencer_rr_arbiter_n.sv
// Round-robin arbiter: one-hot grant searching from the slot after the last
// winner; the pointer only moves when the grant is consumed.
module rr_arbiter_n #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            for (int i = 0; i < N; i++)
                if (gnt[i]) ptr <= PW'((i + 1) % N);
        end
    end
endmodule

// File: rtl/adc_capture_sequencer.sv
// Captures sinc3 channel words into per-channel holding regs and streams them
// round-robin into two ping-pong SRAM banks through a single write port.
module adc_capture_sequencer
    import adc_capture_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [NCH-1:0]    ch_en_i,
    input  logic [AW-1:0]     frame_len_i,
    input  logic [NCH-1:0]    adc_dvalid_i,
    input  logic [NCH*DW-1:0] adc_dat_i,
    input  logic [1:0]        bank_ack_i,
    output logic [1:0]        mem_wenb_o,
    output logic [AW-1:0]     mem_waddr_o,
    output logic [DW-1:0]     mem_data_o,
    output logic [3:0]        wmask_o,
    output logic [1:0]        bank_full_o,
    output logic [AW:0]       fill_cnt_o,
    output logic              active_bank_o,
    output logic              overflow_o,
    output logic              busy_o,
    output logic              irq_o
);
    state_t                   state;
    logic [NCH-1:0]           pend_vld;
    logic [NCH-1:0][DW-1:0]   pend_dat;
    logic [NCH-1:0]           req;
    logic [NCH-1:0]           gnt;
    logic [DW-1:0]            gnt_word;
    logic [1:0]               full_acked;
    logic [AW:0]              len_q;
    logic                     grant_en;

    assign wmask_o    = 4'hF;
    assign grant_en   = (state == RUN) && !stop_i;
    assign req        = grant_en ? pend_vld : '0;
    // Software acks take effect in the same cycle they are seen.
    assign full_acked = bank_full_o & ~bank_ack_i;

    rr_arbiter_n #(.N(NCH)) u_arb (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .req     (req),
        .advance (grant_en),
        .gnt     (gnt)
    );

    always_comb begin
        gnt_word = '0;
        for (int c = 0; c < NCH; c++)
            if (gnt[c]) gnt_word = pend_dat[c];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            pend_vld      <= '0;
            pend_dat      <= '0;
            mem_wenb_o    <= 2'b11;
            mem_waddr_o   <= '0;
            mem_data_o    <= '0;
            bank_full_o   <= '0;
            fill_cnt_o    <= '0;
            active_bank_o <= 1'b0;
            overflow_o    <= 1'b0;
            irq_o         <= 1'b0;
            len_q         <= (AW+1)'(eff_len(0, AW));
        end else begin
            irq_o       <= 1'b0;
            mem_wenb_o  <= 2'b11;
            bank_full_o <= full_acked;
            case (state)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        state         <= RUN;
                        busy_o        <= 1'b1;
                        bank_full_o   <= '0;
                        overflow_o    <= 1'b0;
                        fill_cnt_o    <= '0;
                        active_bank_o <= 1'b0;
                        pend_vld      <= '0;
                        len_q         <= (AW+1)'(eff_len(int'(frame_len_i), AW));
                    end
                end
                default: begin
                    if (stop_i) begin
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        pend_vld <= '0;
                    end else begin
                        if (state == WAIT_BANK && bank_ack_i[~active_bank_o]) begin
                            state         <= RUN;
                            active_bank_o <= ~active_bank_o;
                        end
                        if (|gnt) begin
                            mem_wenb_o  <= active_bank_o ? 2'b01 : 2'b10;
                            mem_waddr_o <= fill_cnt_o[AW-1:0];
                            mem_data_o  <= gnt_word;
                            if (fill_cnt_o == len_q - (AW+1)'(1)) begin
                                bank_full_o <= full_acked | (active_bank_o ? 2'b10 : 2'b01);
                                irq_o       <= 1'b1;
                                fill_cnt_o  <= '0;
                                // Only stall when the other bank is still owned by software.
                                if (full_acked[~active_bank_o]) state <= WAIT_BANK;
                                else                             active_bank_o <= ~active_bank_o;
                            end else begin
                                fill_cnt_o <= fill_cnt_o + (AW+1)'(1);
                            end
                        end
                        for (int c = 0; c < NCH; c++) begin
                            if (adc_dvalid_i[c] && ch_en_i[c]) begin
                                if (pend_vld[c] && !gnt[c]) begin
                                    overflow_o <= 1'b1;
                                end else begin
                                    pend_vld[c] <= 1'b1;
                                    pend_dat[c] <= adc_dat_i[c*DW +: DW];
                                end
                            end else if (gnt[c]) begin
                                pend_vld[c] <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Randomised and directed bench for adc_capture_sequencer against a
// transaction-level model of the capture/ping-pong rules.
module tb_adc_capture_sequencer;
    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int AW  = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            start = 0, stop = 0;
    logic [NCH-1:0]  ch_en = '1;
    logic [AW-1:0]   frame_len = '0;
    logic [NCH-1:0]  dvalid = '0;
    logic [NCH*DW-1:0] dat = '0;
    logic [1:0]      ack = '0;

    logic [1:0]  mem_wenb;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_data;
    logic [3:0]  wmask;
    logic [1:0]  bank_full;
    logic [AW:0] fill_cnt;
    logic        active_bank, overflow, busy, irq;

    adc_capture_sequencer #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .stop_i(stop),
        .ch_en_i(ch_en), .frame_len_i(frame_len), .adc_dvalid_i(dvalid),
        .adc_dat_i(dat), .bank_ack_i(ack), .mem_wenb_o(mem_wenb),
        .mem_waddr_o(mem_waddr), .mem_data_o(mem_data), .wmask_o(wmask),
        .bank_full_o(bank_full), .fill_cnt_o(fill_cnt),
        .active_bank_o(active_bank), .overflow_o(overflow), .busy_o(busy),
        .irq_o(irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode;   // 0 idle, 1 filling, 2 both banks held by software
    logic [1:0]  m_full, m_wenb;
    int          m_fill, m_len, m_ptr, m_waddr;
    logic [31:0] m_data;
    bit          m_act, m_ovf, m_irq;
    bit          pv[NCH];
    logic [31:0] pd[NCH];

    task automatic m_reset();
        m_mode = 0; m_full = 0; m_wenb = 2'b11; m_fill = 0; m_len = 512;
        m_ptr = 0; m_waddr = 0; m_data = 0; m_act = 0; m_ovf = 0; m_irq = 0;
        for (int c = 0; c < NCH; c++) begin pv[c] = 0; pd[c] = 0; end
    endtask

    task automatic m_step();
        int g;
        logic [1:0] fa;
        g = -1;
        m_irq = 0;
        m_wenb = 2'b11;
        fa = m_full & ~ack;
        m_full = fa;
        if (m_mode == 0) begin
            if (start && !stop) begin
                m_mode = 1; m_full = 0; m_ovf = 0; m_fill = 0; m_act = 0;
                m_len = (frame_len == 0) ? 512 : int'(frame_len);
                for (int c = 0; c < NCH; c++) pv[c] = 0;
            end
        end else if (stop) begin
            m_mode = 0;
            for (int c = 0; c < NCH; c++) pv[c] = 0;
        end else begin
            if (m_mode == 2) begin
                if (ack[!m_act]) begin m_act = !m_act; m_mode = 1; end
            end else begin
                for (int i = 0; i < NCH; i++)
                    if (g < 0 && pv[(m_ptr + i) % NCH]) g = (m_ptr + i) % NCH;
                if (g >= 0) begin
                    m_wenb  = m_act ? 2'b01 : 2'b10;
                    m_waddr = m_fill;
                    m_data  = pd[g];
                    m_ptr   = (g + 1) % NCH;
                    if (m_fill == m_len - 1) begin
                        m_full[m_act] = 1'b1;
                        m_irq  = 1;
                        m_fill = 0;
                        if (fa[!m_act]) m_mode = 2;
                        else            m_act = !m_act;
                    end else begin
                        m_fill++;
                    end
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (dvalid[c] && ch_en[c]) begin
                    if (pv[c] && g != c) m_ovf = 1;
                    else begin pv[c] = 1; pd[c] = dat[c*DW +: DW]; end
                end else if (g == c) begin
                    pv[c] = 0;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    // ---------------- compare + write log ----------------
    int wq_b[$], wq_a[$];
    logic [31:0] wq_d[$];
    int irq_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("wenb", mem_wenb, m_wenb);
            if (m_wenb != 2'b11) begin
                chk("waddr", mem_waddr, m_waddr);
                chk("wdata", mem_data, m_data);
            end
            chk("wmask", wmask, 4'hF);
            chk("bank_full", bank_full, m_full);
            chk("fill_cnt", fill_cnt, m_fill);
            chk("active_bank", active_bank, m_act);
            chk("overflow", overflow, m_ovf);
            chk("busy", busy, m_mode != 0);
            chk("irq", irq, m_irq);
            if (mem_wenb != 2'b11) begin
                wq_b.push_back(mem_wenb == 2'b01 ? 1 : 0);
                wq_a.push_back(int'(mem_waddr));
                wq_d.push_back(mem_data);
            end
            if (irq) irq_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_log();
        wq_b.delete(); wq_a.delete(); wq_d.delete(); irq_cnt = 0;
    endtask

    task automatic do_reset();
        start = 0; stop = 0; dvalid = '0; ack = '0; ch_en = '1;
        rst = 1; cyc(2); rst = 0; cyc(1);
    endtask

    task automatic do_start(input int len);
        frame_len = AW'(len); start = 1; cyc(1); start = 0;
    endtask

    task automatic set_dat(input int c, input logic [31:0] v);
        dat[c*DW +: DW] = v;
    endtask

    task automatic sample(input int c, input logic [31:0] v);
        dvalid[c] = 1; set_dat(c, v); cyc(1); dvalid = '0;
    endtask

    initial begin
        // Reset state.
        cyc(2);
        chk("rst_wenb", mem_wenb, 2'b11);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_data, 0);
        chk("rst_wmask", wmask, 4'hF);
        chk("rst_full", bank_full, 0);
        chk("rst_fill", fill_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        rst = 0; cyc(2);

        // Basic fill, frame_len=4 on ch0.
        clr_log(); do_start(4);
        for (int i = 0; i < 4; i++) sample(0, 32'hA0 + i);
        cyc(3);
        chk("basic_nwr", wq_a.size(), 4);
        for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
            chk("basic_addr", wq_a[i], i);
            chk("basic_data", wq_d[i], 32'hA0 + i);
            chk("basic_bank", wq_b[i], 0);
        end
        chk("basic_full", bank_full, 2'b01);
        chk("basic_act", active_bank, 1);
        chk("basic_irq", irq_cnt, 1);

        // Round-robin from a fresh pointer.
        do_reset(); clr_log(); do_start(0);
        dvalid = 3'b111; set_dat(0, 32'h11); set_dat(1, 32'h22); set_dat(2, 32'h33);
        cyc(1); dvalid = '0; cyc(4);
        dvalid = 3'b111; set_dat(0, 32'h44); set_dat(1, 32'h55); set_dat(2, 32'h66);
        cyc(1); dvalid = '0; cyc(4);
        chk("rr_nwr", wq_a.size(), 6);
        for (int i = 0; i < 6 && i < wq_a.size(); i++) begin
            chk("rr_addr", wq_a[i], i);
            chk("rr_data", wq_d[i], (i < 3) ? 32'h11 * (i + 1) : 32'h11 * (i + 1));
        end
        chk("rr_ovf", overflow, 0);

        // Ping-pong stall and overflow.
        do_reset(); clr_log(); do_start(2);
        for (int i = 1; i <= 4; i++) sample(0, i);
        cyc(3);
        sample(0, 5); cyc(2);
        chk("pp_busy", busy, 1);
        chk("pp_full", bank_full, 2'b11);
        chk("pp_nwr", wq_a.size(), 4);
        chk("pp_noovf", overflow, 0);
        sample(0, 6); cyc(1);
        chk("pp_ovf", overflow, 1);
        ack = 2'b01; cyc(1); ack = 0; cyc(2);
        chk("pp_nwr2", wq_a.size(), 5);
        if (wq_a.size() == 5) begin
            chk("pp_bank", wq_b[4], 0);
            chk("pp_addr", wq_a[4], 0);
            chk("pp_data", wq_d[4], 5);
        end
        chk("pp_full2", bank_full, 2'b10);

        // frame_len=0 gives 512 words; back-to-back samples never overflow.
        do_reset(); clr_log(); do_start(0);
        for (int i = 0; i < 512; i++) sample(1, 32'h1000 + i);
        cyc(3);
        chk("f512_nwr", wq_a.size(), 512);
        if (wq_a.size() == 512) begin
            chk("f512_last_addr", wq_a[511], 511);
            chk("f512_last_data", wq_d[511], 32'h1000 + 511);
        end
        chk("f512_full", bank_full, 2'b01);
        chk("f512_ovf", overflow, 0);
        chk("f512_irq", irq_cnt, 1);

        // start together with stop stays idle.
        do_reset();
        start = 1; stop = 1; cyc(1); start = 0; stop = 0; cyc(1);
        chk("ss_busy", busy, 0);

        // stop after 3 writes holds fill count.
        do_start(8);
        for (int i = 0; i < 3; i++) sample(2, 32'hC0 + i);
        cyc(3);
        stop = 1; cyc(1); stop = 0; cyc(1);
        chk("stop_busy", busy, 0);
        chk("stop_fill", fill_cnt, 3);

        // Async reset during an active write.
        do_start(8);
        sample(0, 32'hDEAD);
        @(posedge clk); #2;
        chk("pre_rst_wenb", mem_wenb, 2'b10);
        rst = 1; #1;
        chk("arst_wenb", mem_wenb, 2'b11);
        chk("arst_busy", busy, 0);
        chk("arst_fill", fill_cnt, 0);
        chk("arst_full", bank_full, 0);
        @(negedge clk); rst = 0; cyc(1);

        // Randomised traffic against the model.
        ch_en = '1;
        for (int k = 0; k < 3000; k++) begin
            start = (m_mode == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 299) == 0);
            frame_len = ($urandom_range(0, 19) == 0) ? AW'(0) : AW'($urandom_range(1, 6));
            if ($urandom_range(0, 49) == 0) ch_en = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                dvalid[c] = ($urandom_range(0, 99) < 40);
                set_dat(c, $urandom);
            end
            ack[0] = ($urandom_range(0, 9) == 0);
            ack[1] = ($urandom_range(0, 9) == 0);
            cyc(1);
        end
        start = 0; stop = 0; dvalid = '0; ack = '0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
